// File: rtl/counter_bus_pkg.sv
// Shared state codes, default bus widths and command record for the counter peripheral bus master.
package counter_bus_pkg;

    localparam int CB_ADDR_W = 2;
    localparam int CB_DATA_W = 8;

    // Bus cycle states; a plain 3-bit code keeps the encoding stable for legacy tooling.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP   = 3'd1;
    localparam state_t ST_STROBE  = 3'd2;
    localparam state_t ST_HOLD    = 3'd3;
    localparam state_t ST_RECOVER = 3'd4;

    typedef struct packed {
        logic                 write;
        logic [CB_ADDR_W-1:0] addr;
        logic [CB_DATA_W-1:0] wdata;
    } cmd_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/counter_bus_phase_timer.sv
// Loadable down-counter that times one bus phase; done is high while the count sits at zero.
module counter_bus_phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Holds at zero rather than wrapping, so an idle timer keeps reporting done.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/counter_bus_master.sv
// Valid/ready command stream to csq/wrq/rdq strobe cycles for the 4-channel counter register port.
// Define COUNTER_BUS_MASTER_RDBACK_EN to follow every write with a verifying read of the same register.
module counter_bus_master
    import counter_bus_pkg::*;
#(
    parameter int ADDR_W     = CB_ADDR_W,
    parameter int DATA_W     = CB_DATA_W,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              csq,
    output logic              wrq,
    output logic              rdq,
    output logic [ADDR_W-1:0] abus,
    output logic [DATA_W-1:0] dbus_out,
    output logic              dbus_oe,
    input  logic [DATA_W-1:0] dbus_in
);

    localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);

    if (SETUP_CYC < 1) begin : g_bad_setup
        $error("counter_bus_master: SETUP_CYC must be >= 1");
    end
    if (STROBE_CYC < 1) begin : g_bad_strobe
        $error("counter_bus_master: STROBE_CYC must be >= 1");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("counter_bus_master: HOLD_CYC must be >= 1");
    end

    state_t            state;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pass_wr;
    logic              in_bus;
    logic              accept;
    logic              phase_done;
    logic              timer_load;
    logic [CNT_W-1:0]  timer_val;

    // Handshake: a command transfers on a posedge where cmd_valid and cmd_ready are both high;
    // cmd_ready depends only on the FSM and rst, never on cmd_valid, and the fields are captured then.
    assign cmd_ready = (state == ST_IDLE) & ~rst;
    assign accept    = cmd_valid & cmd_ready;

`ifdef COUNTER_BUS_MASTER_RDBACK_EN
    logic rd_pass;
    logic rsp_err_q;

    // The second pass of a write is a read of the same register.
    assign pass_wr = wr_q & ~rd_pass;
    assign rsp_err = rsp_err_q;
`else
    assign pass_wr = wr_q;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    timer_load = 1'b1;
                    timer_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (phase_done) begin
                    timer_load = 1'b1;
                    timer_val  = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (phase_done) begin
                    timer_load = 1'b1;
                    timer_val  = CNT_W'(HOLD_CYC - 1);
                end
            end
            ST_RECOVER: begin
                timer_load = 1'b1;
                timer_val  = SETUP_LD;
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    counter_bus_phase_timer #(
        .CNT_W(CNT_W)
    ) u_phase_timer (
        .sclk     (sclk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (phase_done)
    );

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef COUNTER_BUS_MASTER_RDBACK_EN
            rd_pass   <= 1'b0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_SETUP;
                        wr_q    <= cmd_write;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
`ifdef COUNTER_BUS_MASTER_RDBACK_EN
                        rd_pass <= 1'b0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (phase_done) begin
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (phase_done) begin
                        state <= ST_HOLD;
                        // Read data is sampled on the edge that closes the last strobe cycle.
                        if (!pass_wr) begin
                            rsp_rdata <= dbus_in;
`ifdef COUNTER_BUS_MASTER_RDBACK_EN
                            rsp_err_q <= rd_pass & (dbus_in != wdata_q);
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_done) begin
`ifdef COUNTER_BUS_MASTER_RDBACK_EN
                        if (pass_wr) begin
                            state <= ST_RECOVER;
                        end else begin
                            state     <= ST_IDLE;
                            rsp_valid <= 1'b1;
                        end
`else
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
`endif
                    end
                end
                ST_RECOVER: begin
`ifdef COUNTER_BUS_MASTER_RDBACK_EN
                    state   <= ST_SETUP;
                    rd_pass <= 1'b1;
`else
                    state <= ST_IDLE;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus pins decode straight from the state flops so reset releases them immediately.
    assign in_bus   = (state == ST_SETUP) | (state == ST_STROBE) | (state == ST_HOLD);
    assign csq      = ~in_bus;
    assign wrq      = ~((state == ST_STROBE) & pass_wr);
    assign rdq      = ~((state == ST_STROBE) & ~pass_wr);
    assign dbus_oe  = in_bus & pass_wr;
    assign abus     = addr_q;
    assign dbus_out = wdata_q;

endmodule

// File: tb/tb_counter_bus_master.sv
// Bench for counter_bus_master: directed and random commands checked cycle by cycle against a timing model.
// Define COUNTER_BUS_MASTER_RDBACK_EN for both bench and design to cover the read-back configuration.
module tb_counter_bus_master;
    import counter_bus_pkg::*;

    localparam int S  = 2;
    localparam int T  = 4;
    localparam int H  = 2;
    localparam int L1 = S + T + H;
`ifdef COUNTER_BUS_MASTER_RDBACK_EN
    localparam bit RDBACK = 1'b1;
`else
    localparam bit RDBACK = 1'b0;
`endif

    logic                 sclk = 1'b0;
    logic                 rst  = 1'b1;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [CB_ADDR_W-1:0] cmd_addr;
    logic [CB_DATA_W-1:0] cmd_wdata;
    logic                 rsp_valid;
    logic [CB_DATA_W-1:0] rsp_rdata;
    logic                 rsp_err;
    logic                 csq;
    logic                 wrq;
    logic                 rdq;
    logic [CB_ADDR_W-1:0] abus;
    logic [CB_DATA_W-1:0] dbus_out;
    logic                 dbus_oe;
    logic [CB_DATA_W-1:0] dbus_in;

    always #5 sclk = ~sclk;

    counter_bus_master #(
        .ADDR_W     (CB_ADDR_W),
        .DATA_W     (CB_DATA_W),
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .HOLD_CYC   (H)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .csq       (csq),
        .wrq       (wrq),
        .rdq       (rdq),
        .abus      (abus),
        .dbus_out  (dbus_out),
        .dbus_oe   (dbus_oe),
        .dbus_in   (dbus_in)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one transaction described by its accept edge and total length.
    bit                   m_act   = 1'b0;
    bit                   m_acc   = 1'b0;
    bit                   m_write = 1'b0;
    bit                   m_err   = 1'b0;
    int                   m_t0    = 0;
    int                   m_len   = 0;
    logic [CB_ADDR_W-1:0] m_addr  = '0;
    logic [CB_DATA_W-1:0] m_wdata = '0;
    logic [CB_DATA_W-1:0] m_rdata = '0;

    logic [CB_DATA_W:0]   exp_q[$];
    int                   acc_cyc      = 0;
    int                   last_rsp_cyc = -1;
    int                   prev_rsp_cyc = -1;
    logic [CB_DATA_W:0]   last_rsp     = '0;
    int                   resp_mode    = 0;
    logic [CB_DATA_W-1:0] resp_val     = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ph: 0 idle, 1 setup, 2 strobe, 3 hold, 4 recover; wp: the current pass drives data; kp: cycle within pass.
    task automatic model_phase(output int ph, output bit wp, output int kp);
        int k;
        k  = cyc - m_t0;
        ph = 0;
        wp = 1'b0;
        kp = 0;
        if (!m_act || k >= m_len) return;
        if (k < L1) begin
            kp = k;
            wp = m_write;
        end else if (k == L1) begin
            ph = 4;
            return;
        end else begin
            kp = k - L1 - 1;
            wp = 1'b0;
        end
        ph = (kp < S) ? 1 : (kp < S + T) ? 2 : 3;
    endtask

    task automatic model_reset();
        m_act   = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int k;
        bit idle_b;
        idle_b = !m_act || (cyc - m_t0 >= m_len);
        cyc++;
        m_acc = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        k = cyc - m_t0;
        if (m_act && !idle_b) begin
            if (!m_write && k == S + T) begin
                m_rdata = dbus_in;
                m_err   = 1'b0;
            end
            if (RDBACK && m_write && k == L1 + 1 + S + T) begin
                m_rdata = dbus_in;
                m_err   = (dbus_in != m_wdata);
            end
        end
        if (idle_b && cmd_valid) begin
            m_act   = 1'b1;
            m_acc   = 1'b1;
            m_t0    = cyc;
            m_write = cmd_write;
            m_addr  = cmd_addr;
            m_wdata = cmd_wdata;
            m_len   = (RDBACK && cmd_write) ? 2 * L1 + 1 : L1;
        end
    endtask

    task automatic compare_all();
        int ph;
        int kp;
        int k;
        bit wp;
        bit exp_bus;
        bit exp_rsp;
        model_phase(ph, wp, kp);
        k       = cyc - m_t0;
        exp_bus = (ph >= 1 && ph <= 3);
        exp_rsp = m_act && (k == m_len) && !rst;
        check_eq("csq", csq, !exp_bus);
        check_eq("wrq", wrq, !(ph == 2 && wp));
        check_eq("rdq", rdq, !(ph == 2 && !wp));
        check_eq("dbus_oe", dbus_oe, exp_bus && wp);
        check_eq("abus", abus, m_addr);
        if (exp_bus && wp) check_eq("dbus_out", dbus_out, m_wdata);
        check_eq("cmd_ready", cmd_ready, !rst && (!m_act || k >= m_len));
        check_eq("rsp_valid", rsp_valid, exp_rsp);
        check_eq("rsp_rdata", rsp_rdata, m_rdata);
        check_eq("rsp_err", rsp_err, m_err);
        if (exp_rsp) exp_q.push_back({m_err, m_rdata});
        if (rsp_valid === 1'b1) begin
            prev_rsp_cyc = last_rsp_cyc;
            last_rsp_cyc = cyc;
            last_rsp     = {rsp_err, rsp_rdata};
            if (exp_q.size() == 0) check_eq("rsp_unexpected", rsp_valid, 0);
            else check_eq("rsp_scoreboard", {rsp_err, rsp_rdata}, exp_q.pop_front());
        end
    endtask

    task automatic drive_responder();
        int ph;
        int kp;
        bit wp;
        model_phase(ph, wp, kp);
        if (resp_mode == 1 && ph == 2 && !wp && kp - S >= 2) dbus_in = resp_val;
        else dbus_in = CB_DATA_W'($urandom);
    endtask

    task automatic tick();
        @(posedge sclk);
        model_edge();
        #1;
        compare_all();
        drive_responder();
    endtask

    task automatic async_reset_pulse();
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #2;
        rst = 1'b0;
        #1;
        compare_all();
    endtask

    task automatic send(input cmd_t c);
        int n;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 40);
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = CB_ADDR_W'($urandom);
        cmd_wdata = CB_DATA_W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_act && (cyc - m_t0 < m_len) && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        cmd_t c;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        dbus_in   = '0;

        repeat (2) tick();
        #2 rst = 1'b0;
        tick();

        // Directed write, address 2, data 0x5A.
        c = '{write: 1'b1, addr: 2'd2, wdata: 8'h5A};
        send(c);
        wait_idle();
        check_eq("wr_latency", last_rsp_cyc - acc_cyc, RDBACK ? 2 * L1 + 1 : L1);

        // Directed read with the responder presenting 0x3C two cycles into the strobe.
        resp_mode = 1;
        resp_val  = 8'h3C;
        c = '{write: 1'b0, addr: 2'd1, wdata: 8'h00};
        send(c);
        wait_idle();
        check_eq("rd_data", last_rsp[CB_DATA_W-1:0], 8'h3C);
        check_eq("rd_latency", last_rsp_cyc - acc_cyc, L1);
        resp_mode = 0;

        // Back-to-back reads with cmd_valid held high.
        last_rsp_cyc = -1;
        c = '{write: 1'b0, addr: 2'd3, wdata: 8'h00};
        send(c);
        c = '{write: 1'b0, addr: 2'd0, wdata: 8'h00};
        send(c);
        wait_idle();
        check_eq("b2b_gap", last_rsp_cyc - prev_rsp_cyc, L1 + 1);

        // Reset pulse in the second strobe cycle of a write, then a clean write.
        c = '{write: 1'b1, addr: 2'd3, wdata: 8'hC3};
        send(c);
        repeat (S + 1) tick();
        async_reset_pulse();
        repeat (3) tick();
        c = '{write: 1'b1, addr: 2'd1, wdata: 8'hA5};
        send(c);
        wait_idle();
        check_eq("post_rst_latency", last_rsp_cyc - acc_cyc, RDBACK ? 2 * L1 + 1 : L1);

        // Reset held across edges while idle.
        rst = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b0;
        tick();

`ifdef COUNTER_BUS_MASTER_RDBACK_EN
        resp_mode = 1;
        resp_val  = 8'h5B;
        c = '{write: 1'b1, addr: 2'd2, wdata: 8'h5A};
        send(c);
        wait_idle();
        check_eq("rdback_err", last_rsp[CB_DATA_W], 1'b1);
        check_eq("rdback_data", last_rsp[CB_DATA_W-1:0], 8'h5B);
        check_eq("rdback_latency", last_rsp_cyc - acc_cyc, 2 * L1 + 1);
        resp_val = 8'h5A;
        send(c);
        wait_idle();
        check_eq("rdback_ok", last_rsp[CB_DATA_W], 1'b0);
        resp_mode = 0;
`endif

        for (int i = 0; i < 60; i++) begin
            c.write = 1'($urandom);
            c.addr  = CB_ADDR_W'($urandom);
            c.wdata = CB_DATA_W'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            send(c);
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(0, 2 * L1)) tick();
                async_reset_pulse();
            end
        end
        wait_idle();
        repeat (2) tick();
        check_eq("rsp_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
